// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: instruction word width, NOP encoding, default
// reset PC and the fetch-queue entry layout.
package pipeline_pkg;

   localparam int                WORD_W           = 32;
   localparam logic [WORD_W-1:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Width of the in-flight and discard trackers; generous so that repeated
   // redirects against a slow memory cannot wrap the discard count.
   localparam int                TRK_W            = 8;

   typedef struct packed {
      logic [WORD_W-1:0] pc_plus1;
      logic [WORD_W-1:0] instr;
   } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc+1, instr} entries with push, pop, flush and
// an occupancy count that discriminates full from empty.
module fetch_fifo
   import pipeline_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  fq_entry_t              push_data_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   output logic                   valid_o,
   output fq_entry_t              data_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int             AW   = $clog2(DEPTH);
   localparam int             CW   = AW + 1;
   localparam logic [AW:0]    FULL = CW'(DEPTH);

   fq_entry_t         mem_q [DEPTH];
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic              do_push, do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != FULL) || do_pop);

   // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; an empty queue is masked by count.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign valid_o = (count_q != '0);
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches, buffers in-order
// responses, and flushes/refetches on redirect while dropping stale responses.
module fetch_queue
   import pipeline_pkg::*;
#(
   parameter int                DEPTH           = 4,
   parameter logic [WORD_W-1:0] RESET_PC        = DEFAULT_RESET_PC,
   parameter int                MAX_OUTSTANDING = 2
) (
   input  logic              clock,
   input  logic              reset,
   output logic              imem_req,
   output logic [WORD_W-1:0] imem_addr,
   input  logic              imem_valid,
   input  logic [WORD_W-1:0] imem_rdata,
   input  logic              redirect,
   input  logic [WORD_W-1:0] redirect_pc,
   input  logic              hold,
   output logic              out_valid,
   output logic [WORD_W-1:0] out_instr,
   output logic [WORD_W-1:0] out_pc_plus1
);

   localparam logic [TRK_W-1:0]  MAX_OUT_T = TRK_W'(MAX_OUTSTANDING);
   localparam logic [WORD_W-1:0] DEPTH_T   = WORD_W'(DEPTH);

   logic [WORD_W-1:0]     fetch_pc_q, fetch_pc_d;
   logic [TRK_W-1:0]      outst_q, outst_d;
   logic [TRK_W-1:0]      discard_q, discard_d;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                  fifo_valid;
   fq_entry_t             fifo_head, push_entry;
   logic [WORD_W-1:0]     occupancy;
   logic                  issue, resp_live, push, pop;

   // Queue slots are reserved at request time, so responses can never overflow.
   assign occupancy = WORD_W'(fifo_count) + WORD_W'(outst_q);
   assign issue     = reset && !redirect && (occupancy < DEPTH_T) && (outst_q < MAX_OUT_T);
   assign resp_live = imem_valid && (discard_q == '0);
   assign push      = resp_live && !redirect;
   assign pop       = fifo_valid && !hold && !redirect;

   // Live requests are consecutive, so the oldest one is fetch_pc - outstanding.
   assign push_entry.pc_plus1 = fetch_pc_q - WORD_W'(outst_q) + 32'd1;
   assign push_entry.instr    = imem_rdata;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      outst_d    = outst_q;
      discard_d  = discard_q;
      if (redirect) begin
         fetch_pc_d = redirect_pc;
         outst_d    = '0;
         discard_d  = discard_q + outst_q - TRK_W'(imem_valid);
      end else begin
         if (issue) fetch_pc_d = fetch_pc_q + 32'd1;
         outst_d = outst_q + TRK_W'(issue) - TRK_W'(resp_live);
         if (imem_valid && !resp_live) discard_d = discard_q - 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_pc_q <= RESET_PC;
         outst_q    <= '0;
         discard_q  <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i       (clock),
      .rst_ni      (reset),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .flush_i     (redirect),
      .valid_o     (fifo_valid),
      .data_o      (fifo_head),
      .count_o     (fifo_count)
   );

   assign imem_req     = issue;
   assign imem_addr    = fetch_pc_q;
   assign out_valid    = fifo_valid;
   assign out_instr    = fifo_valid ? fifo_head.instr : NOP_INSTR;
   assign out_pc_plus1 = fifo_valid ? fifo_head.pc_plus1 : '0;

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: queue entries (power of two, ≥2).
REQ-002 Parameter RESET_PC, default 32'h00000000: first fetch address after reset.
REQ-003 Parameter MAX_OUTSTANDING, default 2: in-flight memory requests allowed.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-005 clock  input  1  sole clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 imem_req  output  1  instruction memory read request this cycle.
REQ-008 imem_addr  output  32  word address of the request; valid when imem_req=1.
REQ-009 imem_valid  input  1  response strobe; responses arrive in request order, latency ≥1 cycle.
REQ-010 imem_rdata  input  32  instruction word; valid when imem_valid=1.
REQ-011 redirect  input  1  branch taken in ID; flush and refetch.
REQ-012 redirect_pc  input  32  new fetch address; sampled when redirect=1.
REQ-013 hold  input  1  downstream stall; head entry is not consumed.
REQ-014 out_valid  output  1  head entry is presented.
REQ-015 out_instr  output  32  head instruction; 32'h00000000 (NOP) when out_valid=0.
REQ-016 out_pc_plus1  output  32  head entry address +1 (word-addressed PC); 0 when out_valid=0.

Function
REQ-017 Fetch PC register holds the next request address; it increments by 1 on each issued request.
REQ-018 imem_req SHALL assert when count + outstanding < DEPTH, outstanding < MAX_OUTSTANDING, and redirect=0.
REQ-019 Each imem_valid pushes {imem_addr_of_request+1, imem_rdata} at the tail, unless the response is marked for discard.
REQ-020 Pop occurs on a rising edge when out_valid=1 and hold=0 and redirect=0.
REQ-021 Latency: a response pushed into an empty queue appears on out_valid the following cycle (registered; no combinational bypass).
REQ-022 Push and pop in the same cycle SHALL both take effect; count is unchanged.
REQ-023 Full (count=DEPTH): no new request is issued; the reservation rule of REQ-018 guarantees no response overflow.
REQ-024 Empty: out_valid=0, outputs per REQ-015/REQ-016; hold has no effect.
REQ-025 Redirect: on the edge it is sampled, the queue empties, fetch PC loads redirect_pc, and every still-outstanding response is counted into a discard counter and dropped on arrival.
REQ-026 Redirect takes priority over pop, push, and hold in the same cycle; out_valid=0 the next cycle.
REQ-027 Requests for redirect_pc may issue the cycle after redirect, including while discarded responses remain in flight.
REQ-028 Read and write pointers wrap modulo DEPTH; the count is the full/empty discriminator (width clog2(DEPTH)+1).
REQ-029 Fetch PC wraps from 32'hFFFFFFFF to 0 without error.

Reset
REQ-030 While reset=0: imem_req=0, out_valid=0, out_instr=0, out_pc_plus1=0, count=0, outstanding=0, discard=0, fetch PC=RESET_PC.
REQ-031 Reset asserted mid-operation SHALL abandon all entries and outstanding requests; responses arriving during reset are ignored.
REQ-032 First imem_req with imem_addr=RESET_PC SHALL occur in the first cycle after reset deasserts.

Structure
REQ-033 Shared package pipeline_pkg holds NOP_INSTR (32'h00000000), the 32-bit word width, and the default RESET_PC.
REQ-034 Storage is a sub-module fetch_fifo (DEPTH x 64 bits, push/pop/flush, count).
REQ-035 Outstanding/discard tracking and the fetch PC live in fetch_queue.

Verification
REQ-036 Reset release with 1-cycle memory -> requests at 0,1,2,...; out_valid from cycle 3 with out_pc_plus1=1,2,3, out_instr equal to memory words 0,1,2.
REQ-037 hold=1 for 6 cycles -> queue fills to 4, imem_req=0, head stays at out_pc_plus1=1; releasing hold -> entries 1..4 delivered in order without loss.
REQ-038 redirect=1, redirect_pc=32'h40, with 2 requests in flight -> both responses dropped; next out_valid shows out_pc_plus1=32'h41.
REQ-039 redirect together with pop and push in one cycle -> out_valid=0 the next cycle, count=0, no entry from before the redirect appears afterwards.
REQ-040 reset pulled low while the queue is full and 2 requests are in flight -> all outputs 0 immediately; after release, fetch restarts at RESET_PC with no stale data.
REQ-041 3-cycle memory latency with fetch PC near 32'hFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 0 in order; outstanding never exceeds 2.
